// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: merges single-cycle ALU results and buffered
// long-latency results onto the register file's single registered write port.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ml_valid,
  output logic        ml_ready,
  input  logic [4:0]  ml_rd,
  input  logic [31:0] ml_data,
  output logic        wsig,
  output logic [4:0]  wadd,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          r_live [DEPTH];
  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          r_wsig;
  logic [4:0]    r_wadd;
  logic [31:0]   r_wdata;

  logic          w_full;
  logic          w_empty;
  logic          w_alu_sel;
  logic          w_pop;
  logic          w_push;
  logic          w_kill;
  logic          w_wr_en;
  logic [4:0]    w_wr_rd;
  logic [31:0]   w_wr_data;

  // Port selection: a full FIFO drains first, then ALU, then FIFO, else idle.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_empty   = (r_count == '0);
    w_alu_sel = !w_full && alu_valid;
    w_pop     = w_full || (!alu_valid && !w_empty);
    w_push    = ml_valid && !w_full;
    w_kill    = w_alu_sel && (alu_rd != 5'd0);
    w_wr_en   = 1'b0;
    w_wr_rd   = r_rd[r_head];
    w_wr_data = r_data[r_head];
    if (w_alu_sel) begin
      w_wr_en   = (alu_rd != 5'd0);
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
    end else if (w_pop) begin
      w_wr_en   = r_live[r_head];
    end
  end

  assign alu_stall = w_full && alu_valid;
  assign ml_ready  = !w_full;
  assign wsig      = r_wsig;
  assign wadd      = r_wadd;
  assign wdata     = r_wdata;

  // Outstanding destinations; slots that are not occupied always have live = 0.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_live[i]) pend_mask[r_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // FIFO storage: pop retires head, ALU write kills older same-rd entries, push lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_live[i] <= 1'b0;
    end else begin
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + PW'(1);
      end
      if (w_kill) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (r_rd[i] == alu_rd) r_live[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_live[r_tail] <= (ml_rd != 5'd0);
        r_rd[r_tail]   <= ml_rd;
        r_data[r_tail] <= ml_data;
        r_tail         <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Write-port register; address and data hold whenever no write is emitted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wsig  <= 1'b0;
      r_wadd  <= '0;
      r_wdata <= '0;
    end else begin
      r_wsig <= w_wr_en;
      if (w_wr_en) begin
        r_wadd  <= w_wr_rd;
        r_wdata <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-written stream/reset sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ml_valid;
  logic        ml_ready;
  logic [4:0]  ml_rd;
  logic [31:0] ml_data;
  logic        wsig;
  logic [4:0]  wadd;
  logic [31:0] wdata;
  logic [31:0] pend_mask;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        e_stall;
    logic        e_ready;
    logic [31:0] e_pend;
    logic        e_wsig;
    logic [4:0]  e_wadd;
    logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ml_valid(ml_valid), .ml_ready(ml_ready), .ml_rd(ml_rd), .ml_data(ml_data),
    .wsig(wsig), .wadd(wadd), .wdata(wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                              input logic st, input logic rdy, input logic [31:0] pend,
                              input logic ws, input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.e_stall = st; v.e_ready = rdy; v.e_pend = pend;
    v.e_wsig = ws; v.e_wadd = wa; v.e_wdata = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    alu_valid = av; alu_rd = ard; alu_data = adata;
    ml_valid = mv; ml_rd = mrd; ml_data = mdata;
  endtask

  // Drive at negedge, check combinational outputs pre-edge, registered outputs post-edge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.av, v.ard, v.adata, v.mv, v.mrd, v.mdata);
    #1;
    chk({tag, " alu_stall"}, 32'(alu_stall), 32'(v.e_stall));
    chk({tag, " ml_ready"},  32'(ml_ready),  32'(v.e_ready));
    chk({tag, " pend_mask"}, pend_mask,      v.e_pend);
    @(posedge clk);
    #1;
    chk({tag, " wsig"},  32'(wsig),  32'(v.e_wsig));
    chk({tag, " wadd"},  32'(wadd),  32'(v.e_wadd));
    chk({tag, " wdata"}, wdata,      v.e_wdata);
  endtask

  initial begin
    // ALU path, x0 write
    tbl[0]  = mk(1, 5,  32'h1234, 0, 0, 0,      0, 1, 32'h0,  1, 5,  32'h1234);
    tbl[1]  = mk(1, 0,  32'h5555, 0, 0, 0,      0, 1, 32'h0,  0, 5,  32'h1234);
    tbl[2]  = mk(0, 0,  32'h0,    0, 0, 0,      0, 1, 32'h0,  0, 5,  32'h1234);
    // fill FIFO under ALU load, then alternate drain / ALU
    tbl[3]  = mk(1, 10, 32'hC0,   1, 1, 32'hA1, 0, 1, 32'h0,  1, 10, 32'hC0);
    tbl[4]  = mk(1, 11, 32'hC1,   1, 2, 32'hA2, 0, 1, 32'h02, 1, 11, 32'hC1);
    tbl[5]  = mk(1, 12, 32'hC2,   1, 3, 32'hA3, 0, 1, 32'h06, 1, 12, 32'hC2);
    tbl[6]  = mk(1, 13, 32'hC3,   1, 4, 32'hA4, 0, 1, 32'h0E, 1, 13, 32'hC3);
    tbl[7]  = mk(1, 14, 32'hC4,   1, 5, 32'hA5, 1, 0, 32'h1E, 1, 1,  32'hA1);
    tbl[8]  = mk(1, 14, 32'hC4,   1, 5, 32'hA5, 0, 1, 32'h1C, 1, 14, 32'hC4);
    tbl[9]  = mk(1, 15, 32'hC5,   1, 6, 32'hA6, 1, 0, 32'h3C, 1, 2,  32'hA2);
    tbl[10] = mk(1, 15, 32'hC5,   1, 6, 32'hA6, 0, 1, 32'h38, 1, 15, 32'hC5);
    tbl[11] = mk(0, 0,  32'h0,    0, 0, 0,      0, 0, 32'h78, 1, 3,  32'hA3);
    tbl[12] = mk(0, 0,  32'h0,    0, 0, 0,      0, 1, 32'h70, 1, 4,  32'hA4);
    tbl[13] = mk(0, 0,  32'h0,    0, 0, 0,      0, 1, 32'h60, 1, 5,  32'hA5);
    tbl[14] = mk(0, 0,  32'h0,    0, 0, 0,      0, 1, 32'h40, 1, 6,  32'hA6);
    tbl[15] = mk(0, 0,  32'h0,    0, 0, 0,      0, 1, 32'h0,  0, 6,  32'hA6);
    // WAW kill of a queued rd 7
    tbl[16] = mk(1, 9,  32'h99,   1, 7, 32'hBEEF, 0, 1, 32'h0,  1, 9, 32'h99);
    tbl[17] = mk(1, 7,  32'h0001, 0, 0, 0,        0, 1, 32'h80, 1, 7, 32'h0001);
    tbl[18] = mk(0, 0,  32'h0,    0, 0, 0,        0, 1, 32'h0,  0, 7, 32'h0001);
    tbl[19] = mk(0, 0,  32'h0,    0, 0, 0,        0, 1, 32'h0,  0, 7, 32'h0001);
    // same-cycle push with the same rd is younger and survives
    tbl[20] = mk(1, 8,  32'h88,   1, 8, 32'h8888, 0, 1, 32'h0,   1, 8, 32'h88);
    tbl[21] = mk(0, 0,  32'h0,    0, 0, 0,        0, 1, 32'h100, 1, 8, 32'h8888);
    // long-latency result to x0 is consumed silently
    tbl[22] = mk(0, 0,  32'h0,    1, 0, 32'hDEAD, 0, 1, 32'h0,   0, 8, 32'h8888);
    tbl[23] = mk(0, 0,  32'h0,    0, 0, 0,        0, 1, 32'h0,   0, 8, 32'h8888);

    // reset held two edges with both sources asserting
    rst = 1'b0;
    drive(1, 3, 32'h77, 1, 9, 32'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("reset wsig",      32'(wsig),      32'h0);
    chk("reset ml_ready",  32'(ml_ready),  32'h1);
    chk("reset alu_stall", 32'(alu_stall), 32'h0);
    chk("reset pend_mask", pend_mask,      32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post-reset wsig", 32'(wsig), 32'h0);
    chk("post-reset pend", pend_mask, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // stream 10 long-latency results with no ALU traffic: pointers wrap, count <= 1
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) drive(0, 0, 0, 1, 5'(k + 1), 32'h100 + 32'(k));
      else        drive(0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("stream%0d ml_ready", k), 32'(ml_ready), 32'h1);
      chk($sformatf("stream%0d pend", k), pend_mask, (k == 0) ? 32'h0 : (32'h1 << k));
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk("stream0 wsig", 32'(wsig), 32'h0);
      end else begin
        chk($sformatf("stream%0d wsig", k),  32'(wsig),  32'h1);
        chk($sformatf("stream%0d wadd", k),  32'(wadd),  32'(k));
        chk($sformatf("stream%0d wdata", k), wdata,      32'h100 + 32'(k - 1));
      end
    end

    // queue three entries behind ALU traffic, then reset for one edge
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 3, 32'h33, 1, 5'(20 + i), 32'h200 + 32'(i));
      @(posedge clk);
      #1;
      chk($sformatf("midrst alu%0d wsig", i), 32'(wsig), 32'h1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst pend before", pend_mask, 32'h0070_0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst wsig", 32'(wsig), 32'h0);
    chk("midrst pend", pend_mask, 32'h0);
    chk("midrst ready", 32'(ml_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst idle%0d wsig", i), 32'(wsig), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter for the pipelined core. It merges single-cycle ALU results and results from long-latency units (multiply/divide, loads) onto the register file's one write port. It drives the register file's `wsig`/`wadd`/`wdata` from posedge registers, so they are stable at the register file's negedge write. Long-latency results are buffered in a small FIFO. A pending-destination mask feeds the hazard unit.

## Interface
- `DEPTH`, 4: long-latency FIFO entries; power of two, ≥2.
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  ALU result not accepted this cycle; the pipeline holds its inputs.
- `ml_valid`  in  1  long-latency result offered.
- `ml_ready`  out  1  FIFO can accept; a transfer occurs when `ml_valid & ml_ready`.
- `ml_rd`  in  5  long-latency destination register.
- `ml_data`  in  32  long-latency result.
- `wsig`  out  1  register file write enable (registered).
- `wadd`  out  5  register file write address (registered).
- `wdata`  out  32  register file write data (registered).
- `pend_mask`  out  32  bit r set when a live FIFO entry targets register r.

## Operation
- **FIFO.** DEPTH entries, each holding {live, rd, data}, with head/tail pointers and a count of 0..DEPTH.
  - `full` = (count == DEPTH); `empty` = (count == 0).
  - `ml_ready = !full`, a combinational function of registered state.
  - A push stores {live = (ml_rd != 0), ml_rd, ml_data} at the tail.
- **Write-port selection.** Evaluated every cycle, in this order:
  1. **full:** pop the head. `alu_stall = alu_valid`, and the ALU result is not accepted.
  2. **!full and alu_valid:** accept the ALU result and drive the write port with it. `alu_stall = 0`, and the FIFO does not pop.
  3. **!full, !alu_valid, !empty:** pop the head.
  4. **Otherwise:** idle.
- **Output register.** Next-cycle values are:
  - `wsig` = 1 when the ALU is selected with `alu_rd != 0`, or when a popped entry is live; 0 in every other case.
  - `wadd` and `wdata` take the selected rd/data.
  - When `wsig` becomes 0, `wadd` and `wdata` hold their previous values.
- **x0 writes.** Writes to register 0 are never emitted (`wsig` = 0), but the result is still consumed.
- **WAW kill.** When an ALU result with `alu_rd != 0` is accepted, every FIFO entry with the same rd has live cleared on that edge.
  - This stops an older queued result from later overwriting the newer ALU value.
  - A push in the same cycle with the same rd is younger and stays live.
- **Pending mask.** `pend_mask[r]` = OR over occupied entries of (live & rd == r). It is combinational from FIFO state, and bit 0 is always 0.
- **Simultaneous push and pop.** Allowed when !full. Count is unchanged, and pointers wrap modulo DEPTH.
- **Reset (`rst` == 0 at posedge).** Clears `wsig`, `wadd`, `wdata`, count, pointers and all live bits. This gives `ml_ready` = 1, `alu_stall` = 0 and `pend_mask` = 0 after reset. An in-flight FIFO content is discarded, and no write is emitted.

## Timing
- ALU result accepted at posedge N drives `wsig`/`wadd`/`wdata` during cycle N+1 (the register file writes at the negedge of N+1).
- A long-latency result pushed at edge N can pop at edge N+1 at the earliest, and is then visible on the port during N+2.
- `alu_stall` and `ml_ready` are combinational from registered count plus `alu_valid`. There is no path from `ml_valid` to `ml_ready`.
- Throughput is one register write per cycle. The FIFO can wait indefinitely under continuous ALU traffic only until it fills; then full forces a drain of one entry per cycle.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with `ml_valid` = 1 and `alu_valid` = 1 → `wsig` = 0, `ml_ready` = 1, `alu_stall` = 0, `pend_mask` = 0; no push retained after release.
- **ALU path:** `alu_valid` = 1, `alu_rd` = 5, `alu_data` = 0x1234 at edge N → `wsig` = 1, `wadd` = 5, `wdata` = 0x1234 in cycle N+1. Then `alu_rd` = 0 → `wsig` = 0.
- **Buffering under load:**
  - Push 4 entries (rd 1..4, data 0xA1..0xA4) while `alu_valid` = 1 every cycle → `ml_ready` falls to 0 after the 4th push, `pend_mask` = 0x1E.
  - The next cycle gives `alu_stall` = 1 and drains rd 1/0xA1.
  - Continued ALU traffic then alternates one drain with one ALU write as the FIFO refills.
- **WAW kill:** queue rd 7/0xBEEF, then accept ALU rd 7/0x0001 before it pops → the port shows rd 7/0x0001 only, the queued entry pops with `wsig` = 0, and `pend_mask[7]` clears on the kill edge.
- **Pointer wrap and same-cycle push/pop:** stream 10 long-latency results with `alu_valid` = 0 → 10 writes in push order, one per cycle, count stays ≤1, and data matches after the pointers wrap.
- **Reset mid-operation:** with 3 entries queued, assert `rst` = 0 for one edge → the FIFO is empty, and none of the 3 entries ever appears on `wsig`.
